// File: rtl/cpu_6502_interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_6502_interrupt_ctrl
//
// Interrupt and reset sequencing controller for a 6502-style core. It decides
// when the micro-sequencer runs the reset or hardware interrupt sequence,
// which vector is fetched, whether stack pushes are real writes, and which B
// bit value goes into the pushed status register.
//
// Ports
//   i_clk             core clock, all state updates on the rising edge
//   i_reset           synchronous active-high reset
//   i_irq_n           maskable interrupt request, level-sensitive, active-low
//   i_nmi_n           non-maskable interrupt, falling-edge-sensitive, active-low
//   i_flag_i          status register I (interrupt disable) flag
//   i_instr_boundary  pulse: sequencer is in its last step (MICRO_EXECUTE)
//   i_vector_fetch    pulse: sequencer is fetching the vector (LOAD_VECTOR)
//   o_init            reset sequence active
//   o_handle_irq      hardware IRQ/NMI sequence active
//   o_vector_addr     vector low-byte address, valid during i_vector_fetch
//   o_stack_write_en  0 turns stack pushes into reads (reset sequence)
//   o_push_b          B bit value for the pushed status register
//   o_nmi_ack         one-cycle pulse after the NMI vector was consumed
// ---------------------------------------------------------------------------
module cpu_6502_interrupt_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_irq_n,
    input  logic        i_nmi_n,
    input  logic        i_flag_i,
    input  logic        i_instr_boundary,
    input  logic        i_vector_fetch,
    output logic        o_init,
    output logic        o_handle_irq,
    output logic [15:0] o_vector_addr,
    output logic        o_stack_write_en,
    output logic        o_push_b,
    output logic        o_nmi_ack
);

    typedef enum logic [1:0] {
        RESET_SEQ = 2'd0,
        RUN       = 2'd1,
        IRQ_SEQ   = 2'd2,
        NMI_SEQ   = 2'd3
    } state_t;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    state_t r_state;
    state_t w_state_next;

    logic r_irq_q;
    logic r_nmi_q;
    logic r_nmi_q_prev;
    logic r_nmi_valid;   // r_nmi_q holds a real sample (not the reset value)
    logic r_nmi_armed;   // a real high level on NMI has been seen since reset
    logic r_nmi_pend;
    logic r_nmi_ack;

    logic w_nmi_edge;
    logic w_irq_req;
    logic w_nmi_vec_sel;
    logic w_nmi_consume;

    // A falling edge only counts once NMI has been observed high after reset,
    // so a line held low through reset does not fire on release.
    assign w_nmi_edge    = r_nmi_armed & r_nmi_q_prev & ~r_nmi_q;
    assign w_irq_req     = ~r_irq_q & ~i_flag_i;
    // The NMI vector wins in every non-reset state, which also implements the
    // hijack of an IRQ sequence or a BRK that is already under way.
    assign w_nmi_vec_sel = (r_state != RESET_SEQ) & r_nmi_pend;
    assign w_nmi_consume = i_vector_fetch & w_nmi_vec_sel;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RESET_SEQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq_q      <= 1'b1;
            r_nmi_q      <= 1'b1;
            r_nmi_q_prev <= 1'b1;
            r_nmi_valid  <= 1'b0;
            r_nmi_armed  <= 1'b0;
            r_nmi_pend   <= 1'b0;
            r_nmi_ack    <= 1'b0;
        end else begin
            r_irq_q      <= i_irq_n;
            r_nmi_q      <= i_nmi_n;
            r_nmi_q_prev <= r_nmi_q;
            r_nmi_valid  <= 1'b1;
            r_nmi_armed  <= r_nmi_armed | (r_nmi_valid & r_nmi_q);
            r_nmi_ack    <= w_nmi_consume;
            // A new edge takes precedence over clearing, so an NMI arriving
            // while the previous vector is fetched is not lost.
            if (w_nmi_edge) begin
                r_nmi_pend <= 1'b1;
            end else if (w_nmi_consume) begin
                r_nmi_pend <= 1'b0;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next     = r_state;
        o_init           = 1'b0;
        o_handle_irq     = 1'b0;
        o_stack_write_en = 1'b1;
        o_push_b         = 1'b0;

        case (r_state)
            RESET_SEQ: begin
                o_init           = 1'b1;
                o_stack_write_en = 1'b0;
                if (i_instr_boundary) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                o_push_b = 1'b1;
                if (i_instr_boundary) begin
                    if (r_nmi_pend) begin
                        w_state_next = NMI_SEQ;
                    end else if (w_irq_req) begin
                        w_state_next = IRQ_SEQ;
                    end
                end
            end
            IRQ_SEQ, NMI_SEQ: begin
                // Always return to RUN: one instruction runs between sequences.
                o_handle_irq = 1'b1;
                if (i_instr_boundary) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RESET_SEQ;
            end
        endcase
    end

    always_comb begin
        if (r_state == RESET_SEQ) begin
            o_vector_addr = VEC_RESET;
        end else if (r_nmi_pend) begin
            o_vector_addr = VEC_NMI;
        end else begin
            o_vector_addr = VEC_IRQ;
        end
    end

    assign o_nmi_ack = r_nmi_ack;

endmodule
